window_match_fsm: RTL

//  Parametrised successor of the two-state arm/evaluate detector.

---
 rtl/window_match_fsm_pkg.sv | 26 ++
 rtl/window_match_fsm_counter.sv | 51 +++++
 rtl/window_match_fsm.sv | 129 ++++++++++++
 3 files changed

// File: rtl/window_match_fsm_pkg.sv
// Shared state encodings, compare modes and the window compare function for window_match_fsm.
package window_match_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int MODE_EXACT    = 0;
   localparam int MODE_AT_LEAST = 1;
   localparam int MODE_AT_MOST  = 2;

   // Decides whether a completed window's ones count is a match under the selected mode.
   function automatic logic cmp(input int tot, input int target, input int mode);
      logic res;
      res = 1'b0;
      case (mode)
         MODE_EXACT:    res = (tot == target);
         MODE_AT_LEAST: res = (tot >= target);
         MODE_AT_MOST:  res = (tot <= target);
         default:       res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/window_match_fsm_counter.sv
// Sample index and ones accumulator for one window; clr has priority over en.
module window_counter #(
   parameter int WIN_LEN = 3,
   parameter int CNT_W   = $clog2(WIN_LEN + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic             w,
   output logic             last,
   output logic [CNT_W-1:0] tot
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_LEN - 1);

   logic [CNT_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] ones_q, ones_d;

   assign last = (idx_q == LAST_IDX);
   assign tot  = ones_q + CNT_W'(w);

   // The last sample wraps both registers so the next window starts without a gap.
   always_comb begin
      idx_d  = idx_q;
      ones_d = ones_q;
      if (clr) begin
         idx_d  = '0;
         ones_d = '0;
      end else if (en) begin
         if (last) begin
            idx_d  = '0;
            ones_d = '0;
         end else begin
            idx_d  = idx_q + CNT_W'(1);
            ones_d = tot;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q  <= '0;
         ones_q <= '0;
      end else begin
         idx_q  <= idx_d;
         ones_q <= ones_d;
      end
   end

endmodule

// File: rtl/window_match_fsm.sv
// Armed window detector: counts w=1 samples over back-to-back WIN_LEN windows and pulses z on a match.
// Optional saturating match statistics are enabled by defining WMF_STATS_EN.
module window_match_fsm
   import window_match_pkg::*;
#(
   parameter int WIN_LEN = 3,
   parameter int TARGET  = 2,
   parameter int MODE    = 0,
   parameter int STAT_W  = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic s,
   input  logic stop,
   input  logic w,
   output logic z,
   output logic win_done,
   output logic busy
`ifdef WMF_STATS_EN
   ,output logic [STAT_W-1:0] match_cnt
`endif
);

   localparam int CNT_W = $clog2(WIN_LEN + 1);

   if (WIN_LEN < 1) begin : g_badWinLen
      $error("window_match_fsm: WIN_LEN must be >= 1");
   end
   if (TARGET > WIN_LEN) begin : g_badTarget
      $error("window_match_fsm: TARGET must be <= WIN_LEN");
   end
   if (MODE < 0 || MODE > 2) begin : g_badMode
      $error("window_match_fsm: MODE must be 0, 1 or 2");
   end
   if (STAT_W < 1) begin : g_badStatW
      $error("window_match_fsm: STAT_W must be >= 1");
   end

   state_t           state_q;
   logic             z_q;
   logic             winDone_q;
   logic             busy_q;
   logic             cntClr;
   logic             cntEn;
   logic             cntLast;
   logic [CNT_W-1:0] cntTot;
   logic             windowMatch;
   logic             armEdge;

   // Holding the counter clear in IDLE means the arming edge never takes a sample.
   assign cntClr      = stop | (state_q == ST_IDLE);
   assign cntEn       = (state_q == ST_RUN) & ~stop;
   assign windowMatch = cmp(int'(32'(cntTot)), TARGET, MODE);
   assign armEdge     = (state_q == ST_IDLE) & s & ~stop;

   window_counter #(
      .WIN_LEN (WIN_LEN),
      .CNT_W   (CNT_W)
   ) u_counter (
      .clk   (clk),
      .reset (reset),
      .clr   (cntClr),
      .en    (cntEn),
      .w     (w),
      .last  (cntLast),
      .tot   (cntTot)
   );

   // stop wins over everything, including a coincident last sample and an arm request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         z_q       <= 1'b0;
         winDone_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         z_q       <= 1'b0;
         winDone_q <= 1'b0;
         if (stop) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (s) begin
                     state_q <= ST_RUN;
                     busy_q  <= 1'b1;
                  end
               end
               ST_RUN: begin
                  if (cntLast) begin
                     z_q       <= windowMatch;
                     winDone_q <= 1'b1;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign z        = z_q;
   assign win_done = winDone_q;
   assign busy     = busy_q;

`ifdef WMF_STATS_EN
   logic [STAT_W-1:0] matchCnt_q;

   // Restarts on every arming edge, holds in IDLE, and saturates instead of wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         matchCnt_q <= '0;
      end else if (armEdge) begin
         matchCnt_q <= '0;
      end else if (cntEn && cntLast && windowMatch && (matchCnt_q != '1)) begin
         matchCnt_q <= matchCnt_q + STAT_W'(1);
      end
   end

   assign match_cnt = matchCnt_q;
`else
   logic unusedArm;
   assign unusedArm = armEdge;
`endif

endmodule
